// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: default datapath widths and the
// redirect-drain state encoding used by the prefetch unit.
package if_pkg;

  localparam int unsigned PC_WIDTH_DEF    = 32;
  localparam int unsigned INSTR_WIDTH_DEF = 32;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with extra-MSB wrap pointers; head entry is read
// combinationally so the consumer sees it in the same cycle.
module if_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by the pointers only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch: credit-limited request issue, in-order response
// buffering, and redirect handling that discards stale responses.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = PC_WIDTH_DEF,
  parameter int unsigned         INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int unsigned         DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_addr,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc4
);

  localparam int unsigned        CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0]        DEPTH_LIM = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);

  fetch_state_e           state_q, state_d;
  logic [CW-1:0]          drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          buf_count;
  logic [CW-1:0]          drop_load;
  logic [PC_WIDTH-1:0]    fetch_pc;
  logic [PC_WIDTH-1:0]    head_pc;
  logic [INSTR_WIDTH-1:0] head_instr;
  logic                   buf_empty;
  logic                   req_fire;
  logic                   rsp_fire;
  logic                   rsp_keep;
  logic                   pop;

  // Credit: buffered entries plus in-flight requests may never exceed DEPTH.
  assign imem_req_valid = rst && !branch_taken &&
                          (({1'b0, buf_count} + {1'b0, outstanding}) < DEPTH_LIM);
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding can only belong to a pre-reset request.
  assign rsp_fire  = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep  = rsp_fire && (state_q == RUN) && !branch_taken;
  assign drop_load = outstanding - (rsp_fire ? CNT_ONE : '0);

  assign instr_valid = !buf_empty;
  assign pop         = instr_valid && !freeze && !branch_taken;
  assign instr       = instr_valid ? head_instr : '0;
  assign pc4         = instr_valid ? head_pc + PC_STEP : '0;

  if_fifo #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_taken),
    .push  (rsp_keep),
    .pop   (pop),
    .wdata (imem_rsp_data),
    .rdata (head_instr),
    .empty (buf_empty),
    .count (buf_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
    end else begin
      case ({req_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: ;
      endcase
      if (branch_taken) begin
        fetch_pc <= branch_addr;
        head_pc  <= branch_addr;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (pop)      head_pc  <= head_pc + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: defaults first so no path through this block leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    if (branch_taken) begin
      drop_cnt_d = drop_load;
      state_d    = (drop_load != '0) ? DRAIN : RUN;
    end else if ((state_q == DRAIN) && rsp_fire) begin
      drop_cnt_d = drop_cnt_q - CNT_ONE;
      if (drop_cnt_q == CNT_ONE) state_d = RUN;
    end
  end

endmodule
